// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace streamer: record layout, serialiser states and meta-word bit positions.
// The optional drop counter is enabled by defining IBEX_TRACE_DROP_CNT_EN.
package ibex_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] wdata;
    logic [31:0] meta;
  } trace_rec_t;

  typedef enum logic [1:0] {
    S_PC    = 2'd0,
    S_INSN  = 2'd1,
    S_WDATA = 2'd2,
    S_META  = 2'd3
  } ser_state_e;

  localparam int unsigned META_RD_LSB    = 0;
  localparam int unsigned META_RD_MSB    = 4;
  localparam int unsigned META_TRAP      = 5;
  localparam int unsigned META_INTR      = 6;
  localparam int unsigned META_MODE_LSB  = 7;
  localparam int unsigned META_MODE_MSB  = 8;
  localparam int unsigned META_DROP      = 9;
  localparam int unsigned META_ORDER_LSB = 16;
  localparam int unsigned META_ORDER_MSB = 31;

  function automatic logic [31:0] build_meta(input logic [4:0]  rd_addr,
                                             input logic        trap,
                                             input logic        intr,
                                             input logic [1:0]  mode,
                                             input logic        drop_before,
                                             input logic [15:0] order);
    logic [31:0] meta;
    meta = '0;
    meta[META_RD_MSB:META_RD_LSB]       = rd_addr;
    meta[META_TRAP]                     = trap;
    meta[META_INTR]                     = intr;
    meta[META_MODE_MSB:META_MODE_LSB]   = mode;
    meta[META_DROP]                     = drop_before;
    meta[META_ORDER_MSB:META_ORDER_LSB] = order;
    return meta;
  endfunction

endpackage

// File: rtl/ibex_trace_rec_fifo.sv
// Record FIFO for the trace streamer. A push into a full FIFO is taken when a pop
// happens in the same cycle; pointers wrap naturally because Depth is a power of two.
module ibex_trace_rec_fifo
  import ibex_trace_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter type         rec_t = trace_rec_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  rec_t wdata_i,
  input  logic pop_i,
  output rec_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  rec_t            mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign pop_en  = pop_i & ~empty_o;
  assign push_en = push_i & (~full_o | pop_en);
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ibex_trace_streamer.sv
// Captures RVFI retirements into a record FIFO and serialises each as PC/INSN/WDATA/META words.
// Define IBEX_TRACE_DROP_CNT_EN to build the saturating 16-bit dropped-record counter.
module ibex_trace_streamer
  import ibex_trace_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        rvfi_valid_i,
  input  logic [63:0] rvfi_order_i,
  input  logic [31:0] rvfi_pc_rdata_i,
  input  logic [31:0] rvfi_insn_i,
  input  logic [4:0]  rvfi_rd_addr_i,
  input  logic [31:0] rvfi_rd_wdata_i,
  input  logic        rvfi_trap_i,
  input  logic        rvfi_intr_i,
  input  logic [1:0]  rvfi_mode_i,
  output logic        trace_valid_o,
  input  logic        trace_ready_i,
  output logic [31:0] trace_data_o,
  output logic        trace_last_o,
  output logic        overflow_o,
  output logic [15:0] drop_cnt_o,
  input  logic        clr_ovf_i,
  output ser_state_e  dbg_state_o
);

  // Sink handshake: a word transfers in any cycle with trace_valid_o & trace_ready_i;
  // trace_data_o/trace_last_o hold steady while valid is high and ready is low.

  ser_state_e state_q, state_d;
  trace_rec_t rec_in, head;
  logic       capture, accept, drop, hs, pop;
  logic       full, empty;
  logic       drop_pend_q, overflow_q;
  logic       unused_order;

  assign unused_order = ^rvfi_order_i[63:16];

  assign capture       = rvfi_valid_i & enable_i;
  assign trace_valid_o = ~empty;
  assign hs            = trace_valid_o & trace_ready_i;
  assign pop           = hs & (state_q == S_META);
  assign accept        = capture & (~full | pop);
  assign drop          = capture & ~accept;

  assign rec_in.pc    = rvfi_pc_rdata_i;
  assign rec_in.insn  = rvfi_insn_i;
  assign rec_in.wdata = rvfi_rd_wdata_i;
  assign rec_in.meta  = build_meta(rvfi_rd_addr_i, rvfi_trap_i, rvfi_intr_i, rvfi_mode_i,
                                   drop_pend_q, rvfi_order_i[15:0]);

  ibex_trace_rec_fifo #(
    .Depth (Depth),
    .rec_t (trace_rec_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .wdata_i (rec_in),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    if (hs) begin
      case (state_q)
        S_PC:    state_d = S_INSN;
        S_INSN:  state_d = S_WDATA;
        S_WDATA: state_d = S_META;
        default: state_d = S_PC;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_PC;
    else         state_q <= state_d;
  end

  assign dbg_state_o = state_q;

  // Output is forced to zero when nothing is buffered so stale storage never leaks out.
  always_comb begin
    trace_data_o = '0;
    trace_last_o = 1'b0;
    if (trace_valid_o) begin
      case (state_q)
        S_PC:    trace_data_o = head.pc;
        S_INSN:  trace_data_o = head.insn;
        S_WDATA: trace_data_o = head.wdata;
        default: begin
          trace_data_o = head.meta;
          trace_last_o = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (drop)        drop_pend_q <= 1'b1;
      else if (accept) drop_pend_q <= 1'b0;
      if (drop)           overflow_q <= 1'b1;
      else if (clr_ovf_i) overflow_q <= 1'b0;
    end
  end

  assign overflow_o = overflow_q;

`ifdef IBEX_TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (clr_ovf_i)                 drop_cnt_q <= 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end else if (clr_ovf_i) begin
      drop_cnt_q <= '0;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibex_trace_streamer.sv
// Directed bench for ibex_trace_streamer: single record, backpressure, enable gating,
// overflow/drop accounting, full-plus-pop acceptance and reset mid-record.
module tb_ibex_trace_streamer;
  import ibex_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic        rvfi_valid_i;
  logic [63:0] rvfi_order_i;
  logic [31:0] rvfi_pc_rdata_i;
  logic [31:0] rvfi_insn_i;
  logic [4:0]  rvfi_rd_addr_i;
  logic [31:0] rvfi_rd_wdata_i;
  logic        rvfi_trap_i;
  logic        rvfi_intr_i;
  logic [1:0]  rvfi_mode_i;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_data_o;
  logic        trace_last_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;
  logic        clr_ovf_i;
  ser_state_e  dbg_state_o;

  int errors = 0;
  int checks = 0;

`ifdef IBEX_TRACE_DROP_CNT_EN
  localparam logic [31:0] EXP_CNT_TWO = 32'd2;
  localparam logic [31:0] EXP_CNT_ONE = 32'd1;
`else
  localparam logic [31:0] EXP_CNT_TWO = 32'd0;
  localparam logic [31:0] EXP_CNT_ONE = 32'd0;
`endif

  ibex_trace_streamer #(.Depth(4)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .enable_i        (enable_i),
    .rvfi_valid_i    (rvfi_valid_i),
    .rvfi_order_i    (rvfi_order_i),
    .rvfi_pc_rdata_i (rvfi_pc_rdata_i),
    .rvfi_insn_i     (rvfi_insn_i),
    .rvfi_rd_addr_i  (rvfi_rd_addr_i),
    .rvfi_rd_wdata_i (rvfi_rd_wdata_i),
    .rvfi_trap_i     (rvfi_trap_i),
    .rvfi_intr_i     (rvfi_intr_i),
    .rvfi_mode_i     (rvfi_mode_i),
    .trace_valid_o   (trace_valid_o),
    .trace_ready_i   (trace_ready_i),
    .trace_data_o    (trace_data_o),
    .trace_last_o    (trace_last_o),
    .overflow_o      (overflow_o),
    .drop_cnt_o      (drop_cnt_o),
    .clr_ovf_i       (clr_ovf_i),
    .dbg_state_o     (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_rec(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                         input logic [31:0] wdata, input logic [63:0] order,
                         input logic trap, input logic intr, input logic [1:0] mode);
    rvfi_pc_rdata_i = pc;
    rvfi_insn_i     = insn;
    rvfi_rd_addr_i  = rd;
    rvfi_rd_wdata_i = wdata;
    rvfi_order_i    = order;
    rvfi_trap_i     = trap;
    rvfi_intr_i     = intr;
    rvfi_mode_i     = mode;
  endtask

  task automatic retire_one();
    rvfi_valid_i = 1'b1;
    @(posedge clk); #1;
    rvfi_valid_i = 1'b0;
  endtask

  // Called at posedge+1; samples on the falling edge, then steps past the next rising edge.
  task automatic expect_word(input string tag, input logic [31:0] data, input logic last);
    @(negedge clk);
    check({tag, "_valid"}, 32'(trace_valid_o), 32'd1);
    check({tag, "_data"},  trace_data_o, data);
    check({tag, "_last"},  32'(trace_last_o), 32'(last));
    @(posedge clk); #1;
  endtask

  task automatic expect_rec(input string tag, input logic [31:0] pc, input logic [31:0] insn,
                            input logic [31:0] wdata, input logic [31:0] meta);
    expect_word({tag, "_pc"},    pc,    1'b0);
    expect_word({tag, "_insn"},  insn,  1'b0);
    expect_word({tag, "_wdata"}, wdata, 1'b0);
    expect_word({tag, "_meta"},  meta,  1'b1);
  endtask

  initial begin
    rst_ni        = 1'b0;
    enable_i      = 1'b1;
    rvfi_valid_i  = 1'b0;
    trace_ready_i = 1'b1;
    clr_ovf_i     = 1'b0;
    set_rec(32'h0, 32'h0, 5'd0, 32'h0, 64'd0, 1'b0, 1'b0, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(trace_valid_o), 32'd0);
    check("rst_last",  32'(trace_last_o), 32'd0);
    check("rst_data",  trace_data_o, 32'h0);
    check("rst_ovf",   32'(overflow_o), 32'd0);
    check("rst_cnt",   32'(drop_cnt_o), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(S_PC));
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // single retire, PC word one cycle after capture
    check("idle_valid", 32'(trace_valid_o), 32'd0);
    set_rec(32'h0000_0080, 32'h0010_0093, 5'd1, 32'd1, 64'd5, 1'b0, 1'b0, 2'd0);
    retire_one();
    expect_rec("single", 32'h0000_0080, 32'h0010_0093, 32'h1, 32'h0005_0001);
    check("single_done", 32'(trace_valid_o), 32'd0);

    // backpressure on the INSN word
    set_rec(32'h0000_0100, 32'h0020_0113, 5'd2, 32'd2, 64'd6, 1'b0, 1'b0, 2'd3);
    retire_one();
    expect_word("bp_pc", 32'h0000_0100, 1'b0);
    trace_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(trace_valid_o), 32'd1);
      check("bp_hold_data",  trace_data_o, 32'h0020_0113);
      @(posedge clk); #1;
    end
    trace_ready_i = 1'b1;
    expect_word("bp_insn",  32'h0020_0113, 1'b0);
    expect_word("bp_wdata", 32'h0000_0002, 1'b0);
    expect_word("bp_meta",  32'h0006_0182, 1'b1);

    // enable dropped while a record is in flight: it drains, nothing new is taken
    set_rec(32'h0000_0140, 32'h0030_0193, 5'd3, 32'd3, 64'd7, 1'b1, 1'b1, 2'd0);
    retire_one();
    enable_i     = 1'b0;
    rvfi_valid_i = 1'b1;
    set_rec(32'h0000_0999, 32'h0000_0013, 5'd9, 32'd9, 64'd99, 1'b0, 1'b0, 2'd0);
    expect_rec("en", 32'h0000_0140, 32'h0030_0193, 32'h3, 32'h0007_0063);
    check("en_off_valid", 32'(trace_valid_o), 32'd0);
    rvfi_valid_i = 1'b0;
    enable_i     = 1'b1;

    // overflow: six retires into a stalled Depth-4 FIFO
    trace_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_rec(32'h200 + 32'(4 * i), 32'h0000_0013, 5'(i), 32'(i), 64'(10 + i), 1'b0, 1'b0, 2'd0);
      rvfi_valid_i = 1'b1;
      @(posedge clk); #1;
    end
    rvfi_valid_i = 1'b0;
    check("ovf_flag",  32'(overflow_o), 32'd1);
    check("ovf_cnt",   32'(drop_cnt_o), EXP_CNT_TWO);
    check("ovf_head",  trace_data_o, 32'h0000_0200);

    // clear and drop in the same cycle: the drop wins
    set_rec(32'h0000_0260, 32'h0000_0013, 5'd6, 32'd6, 64'd16, 1'b0, 1'b0, 2'd0);
    rvfi_valid_i = 1'b1;
    clr_ovf_i    = 1'b1;
    @(posedge clk); #1;
    rvfi_valid_i = 1'b0;
    clr_ovf_i    = 1'b0;
    check("clrdrop_flag", 32'(overflow_o), 32'd1);
    check("clrdrop_cnt",  32'(drop_cnt_o), EXP_CNT_ONE);
    clr_ovf_i = 1'b1;
    @(posedge clk); #1;
    clr_ovf_i = 1'b0;
    check("clr_flag", 32'(overflow_o), 32'd0);
    check("clr_cnt",  32'(drop_cnt_o), 32'd0);

    // full FIFO, retire coincides with the META handshake
    trace_ready_i = 1'b1;
    expect_word("full_pc",    32'h0000_0200, 1'b0);
    expect_word("full_insn",  32'h0000_0013, 1'b0);
    expect_word("full_wdata", 32'h0000_0000, 1'b0);
    set_rec(32'h0000_0300, 32'h0000_0033, 5'd7, 32'h77, 64'd20, 1'b0, 1'b0, 2'd0);
    rvfi_valid_i = 1'b1;
    expect_word("full_meta", 32'h000A_0000, 1'b1);
    rvfi_valid_i = 1'b0;
    check("fullpop_flag", 32'(overflow_o), 32'd0);
    check("fullpop_cnt",  32'(drop_cnt_o), 32'd0);
    expect_rec("r1", 32'h0000_0204, 32'h0000_0013, 32'h1, 32'h000B_0001);
    expect_rec("r2", 32'h0000_0208, 32'h0000_0013, 32'h2, 32'h000C_0002);
    expect_rec("r3", 32'h0000_020C, 32'h0000_0013, 32'h3, 32'h000D_0003);
    expect_rec("r7", 32'h0000_0300, 32'h0000_0033, 32'h77, 32'h0014_0207);
    check("drain_valid", 32'(trace_valid_o), 32'd0);

    // reset after the INSN word has gone out
    set_rec(32'h0000_0400, 32'h0040_0213, 5'd4, 32'h44, 64'd30, 1'b0, 1'b0, 2'd0);
    retire_one();
    expect_word("rr_pc",   32'h0000_0400, 1'b0);
    expect_word("rr_insn", 32'h0040_0213, 1'b0);
    rst_ni = 1'b0;
    #1;
    check("rr_valid", 32'(trace_valid_o), 32'd0);
    check("rr_state", 32'(dbg_state_o), 32'(S_PC));
    check("rr_data",  trace_data_o, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rr_quiet", 32'(trace_valid_o), 32'd0);
    end
    set_rec(32'h0000_0500, 32'h0050_0293, 5'd5, 32'h55, 64'd31, 1'b0, 1'b0, 2'd0);
    retire_one();
    expect_rec("rr_next", 32'h0000_0500, 32'h0050_0293, 32'h55, 32'h001F_0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_trace_streamer.md
IBEX_TRACE_STREAMER -- requirements
Module: ibex_trace_streamer

Interface
REQ-001 SHALL have parameter Depth, default 4, record FIFO depth (power of two, >=2).
REQ-002 SHALL have ports clk_i  in  1  clock; rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports:
- enable_i  in  1  capture enable.
- rvfi_valid_i  in  1  retirement strobe.
- rvfi_order_i  in  64  retirement order.
- rvfi_pc_rdata_i  in  32  retired PC.
- rvfi_insn_i  in  32  instruction.
- rvfi_rd_addr_i  in  5  destination register.
- rvfi_rd_wdata_i  in  32  writeback data.
- rvfi_trap_i  in  1  trap.
- rvfi_intr_i  in  1  first instruction of handler.
- rvfi_mode_i  in  2  privilege mode.
REQ-004 SHALL have ports:
- trace_valid_o  out  1  word valid.
- trace_ready_i  in  1  sink ready.
- trace_data_o  out  32  word.
- trace_last_o  out  1  final word of record.
- overflow_o  out  1  sticky drop flag.
- drop_cnt_o  out  16  dropped-record count.
- clr_ovf_i  in  1  clears overflow_o and drop_cnt_o.

Function
REQ-005 SHALL capture a record when rvfi_valid_i & enable_i; the record is the PC, insn, rd_wdata and meta fields.
REQ-006 Meta word SHALL be:
- [4:0] rd_addr, [5] trap, [6] intr, [8:7] mode.
- [9] drop_before: at least one record was dropped since the previous accepted record.
- [15:10] 0, [31:16] rvfi_order[15:0].
REQ-007 Records SHALL be stored in a FIFO of Depth entries. A push is accepted if the FIFO is not full, or if the head record's last word completes in the same cycle.
REQ-008 A capture not accepted SHALL be dropped. A drop sets overflow_o and increments drop_cnt_o, saturating at 16'hFFFF. It also sets a pending flag, copied into meta[9] of the next accepted record and then cleared.
REQ-009 Each record SHALL be serialised as four words in order: PC, INSN, WDATA, META. trace_last_o is 1 only on META.
REQ-010 The serialiser FSM SHALL have states S_PC, S_INSN, S_WDATA, S_META and no IDLE state.
- It advances one state on trace_valid_o & trace_ready_i.
- S_META with a handshake returns to S_PC and pops the FIFO.
- The FSM holds its state while the FIFO is empty.
REQ-011 trace_valid_o SHALL equal FIFO-not-empty. trace_data_o and trace_last_o SHALL stay stable while trace_valid_o & !trace_ready_i.
REQ-012 Latency: a record accepted in cycle N SHALL present its PC word with trace_valid_o=1 in cycle N+1 when the FIFO was empty. Sustained throughput is one word per cycle.
REQ-013 Deasserting enable_i SHALL stop captures only; buffered records and any record in flight drain fully.
REQ-014 When clr_ovf_i and a drop occur in the same cycle, the drop SHALL win: overflow_o=1 and drop_cnt_o=1.
REQ-015 FIFO pointers SHALL wrap modulo Depth; the count SHALL be log2(Depth)+1 bits wide.

Reset
REQ-016 Reset SHALL clear the FIFO, the pending drop flag, overflow_o and drop_cnt_o, and set the FSM to S_PC. After reset, trace_valid_o=0, trace_last_o=0 and trace_data_o=0.
REQ-017 Reset during a partial record SHALL discard it; no remaining words are emitted after reset.

Configuration
REQ-018 With macro IBEX_TRACE_DROP_CNT_EN defined, the 16-bit saturating drop counter SHALL be built.
REQ-019 Without IBEX_TRACE_DROP_CNT_EN, drop_cnt_o SHALL be tied to 0 and no counter flops SHALL exist. overflow_o and meta[9] behave unchanged.

Structure
REQ-020 Package ibex_trace_pkg SHALL hold trace_rec_t, the serialiser state enum, and the meta bit-position constants.
REQ-021 Record storage SHALL be sub-module ibex_trace_rec_fifo, parameterised by Depth and type trace_rec_t. It has push/pop/full/empty ports.

Verification
REQ-022 Single retire: PC=32'h0000_0080, insn=32'h0010_0093, rd=1, wdata=1, order=5, trace_ready_i=1 -> the next four cycles emit 80, 00100093, 1, 32'h0005_0001, with last asserted on the fourth.
REQ-023 Backpressure: hold trace_ready_i=0 for 3 cycles on the INSN word -> trace_data_o stays 32'h0010_0093 and valid stays 1 throughout.
REQ-024 Overflow: Depth=4, trace_ready_i=0, 6 consecutive retires -> 4 records stored, drop_cnt_o=2 (0 without the macro), overflow_o=1. The next accepted record has meta[9]=1.
REQ-025 Full plus pop same cycle: FIFO full, a META handshake coincides with a retire -> the retire is accepted and drop_cnt_o is unchanged.
REQ-026 Reset after the INSN word is sent -> valid=0, the FSM is in S_PC, and the next record emitted starts with its PC word.
